mem_arbiter: RTL



---
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/mem_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch (imem) and load/store (dmem) requester
// ports plus the shared downstream memory port.
//   slave  : arbiter view (takes requests, issues downstream transactions)
//   master : environment view (core requesters and memory fabric)
interface mem_arbiter_if;
    // Fetch requester
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_error;
    logic [31:0] imem_rdata;

    // Load/store requester
    logic        dmem_valid;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic        dmem_error;
    logic [31:0] dmem_rdata;

    // Downstream memory/peripheral port
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [2:0]  mem_sel;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport slave (
        input  imem_valid, imem_addr,
        output imem_ready, imem_error, imem_rdata,
        input  dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_ready, dmem_error, dmem_rdata,
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, mem_sel,
        input  mem_ready, mem_rdata
    );

    modport master (
        output imem_valid, imem_addr,
        input  imem_ready, imem_error, imem_rdata,
        output dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_ready, dmem_error, dmem_rdata,
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, mem_sel,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one downstream memory port between the fetch (imem)
// and load/store (dmem) requesters. Decodes BRAM / print / CLINT windows,
// drives a one-hot target select {clint, print, bram}, and answers
// out-of-map accesses locally with an error response. One transaction is
// outstanding at a time (IDLE -> BUSY -> RESP, or IDLE -> RESP on a miss).
//
// Optional feature: define ARBITER_RR_EN for round-robin arbitration on
// contention; otherwise dmem has fixed priority over imem.
module mem_arbiter #(
    parameter logic [31:0] bram_base_addr  = 32'h0000_0000,
    parameter logic [31:0] bram_top_addr   = 32'h0010_0000,
    parameter logic [31:0] print_base_addr = 32'h0100_0000,
    parameter logic [31:0] print_top_addr  = 32'h0100_0004,
    parameter logic [31:0] clint_base_addr = 32'h0200_0000,
    parameter logic [31:0] clint_top_addr  = 32'h0200_C000
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        gnt_imem_q, gnt_imem_d;     // current grant: 1 = imem, 0 = dmem
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [2:0]  sel_q, sel_d;
    logic        mem_valid_q, mem_valid_d;
    logic        imem_ready_q, imem_ready_d;
    logic        imem_error_q, imem_error_d;
    logic        dmem_ready_q, dmem_ready_d;
    logic        dmem_error_q, dmem_error_d;
    logic [31:0] rdata_q, rdata_d;
`ifdef ARBITER_RR_EN
    logic        last_imem_q, last_imem_d;   // last grant went to imem
`endif

    logic        any_valid;
    logic        pick_imem;
    logic [31:0] req_addr;
    logic [2:0]  req_sel;

    // Window test as (a - base) < (top - base): equivalent to
    // base <= a < top for base <= top, without a constant compare when base is 0.
    function automatic logic in_window(input logic [31:0] a,
                                       input logic [31:0] base,
                                       input logic [31:0] top);
        return (a - base) < (top - base);
    endfunction

    // Address decode with priority bram, print, clint; zero means miss.
    function automatic logic [2:0] decode_sel(input logic [31:0] a);
        if (in_window(a, bram_base_addr, bram_top_addr))
            return 3'b001;
        else if (in_window(a, print_base_addr, print_top_addr))
            return 3'b010;
        else if (in_window(a, clint_base_addr, clint_top_addr))
            return 3'b100;
        else
            return 3'b000;
    endfunction

    // Grant selection for the request considered in IDLE.
    always_comb begin
        any_valid = bus.imem_valid | bus.dmem_valid;
`ifdef ARBITER_RR_EN
        if (bus.imem_valid && bus.dmem_valid)
            pick_imem = ~last_imem_q;
        else
            pick_imem = bus.imem_valid;
`else
        pick_imem = bus.imem_valid & ~bus.dmem_valid;
`endif
        req_addr = pick_imem ? bus.imem_addr : bus.dmem_addr;
        req_sel  = decode_sel(req_addr);
    end

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d      = state_q;
        gnt_imem_d   = gnt_imem_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        sel_d        = sel_q;
        mem_valid_d  = mem_valid_q;
        rdata_d      = rdata_q;
        imem_ready_d = 1'b0;
        imem_error_d = 1'b0;
        dmem_ready_d = 1'b0;
        dmem_error_d = 1'b0;
`ifdef ARBITER_RR_EN
        last_imem_d  = last_imem_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    gnt_imem_d = pick_imem;
`ifdef ARBITER_RR_EN
                    last_imem_d = pick_imem;
`endif
                    if (req_sel != 3'b000) begin
                        addr_d      = req_addr;
                        wdata_d     = pick_imem ? '0 : bus.dmem_wdata;
                        wstrb_d     = pick_imem ? '0 : bus.dmem_wstrb;
                        sel_d       = req_sel;
                        mem_valid_d = 1'b1;
                        state_d     = BUSY;
                    end else begin
                        // Decode miss: answer locally, nothing goes downstream.
                        sel_d   = '0;
                        rdata_d = '0;
                        if (pick_imem) begin
                            imem_ready_d = 1'b1;
                            imem_error_d = 1'b1;
                        end else begin
                            dmem_ready_d = 1'b1;
                            dmem_error_d = 1'b1;
                        end
                        state_d = RESP;
                    end
                end
            end
            BUSY: begin
                if (bus.mem_ready) begin
                    rdata_d     = bus.mem_rdata;
                    mem_valid_d = 1'b0;
                    if (gnt_imem_q)
                        imem_ready_d = 1'b1;
                    else
                        dmem_ready_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered-output flops with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            gnt_imem_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            sel_q        <= '0;
            mem_valid_q  <= 1'b0;
            rdata_q      <= '0;
            imem_ready_q <= 1'b0;
            imem_error_q <= 1'b0;
            dmem_ready_q <= 1'b0;
            dmem_error_q <= 1'b0;
`ifdef ARBITER_RR_EN
            last_imem_q  <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            gnt_imem_q   <= gnt_imem_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            sel_q        <= sel_d;
            mem_valid_q  <= mem_valid_d;
            rdata_q      <= rdata_d;
            imem_ready_q <= imem_ready_d;
            imem_error_q <= imem_error_d;
            dmem_ready_q <= dmem_ready_d;
            dmem_error_q <= dmem_error_d;
`ifdef ARBITER_RR_EN
            last_imem_q  <= last_imem_d;
`endif
        end
    end

    assign bus.mem_valid  = mem_valid_q;
    assign bus.mem_instr  = gnt_imem_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_wstrb  = wstrb_q;
    assign bus.mem_sel    = sel_q;
    assign bus.imem_ready = imem_ready_q;
    assign bus.imem_error = imem_error_q;
    assign bus.imem_rdata = rdata_q;
    assign bus.dmem_ready = dmem_ready_q;
    assign bus.dmem_error = dmem_error_q;
    assign bus.dmem_rdata = rdata_q;

endmodule
